// File: rtl/n64_poll_scheduler.sv
// n64_poll_scheduler: APB3 slave that runs periodic read rounds over both N64 controller ports.
// Latency: period tick -> poll_req[0] next cycle; P1 completion -> poll_req[1] two cycles later.
// Backpressure: none; APB has zero wait states, and ticks/kicks arriving mid-round are dropped and flagged.
module n64_poll_scheduler #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'd1_000_000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd20_000,
  parameter int          ADDR_W         = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [1:0]        poll_req,
  input  logic [1:0]        poll_done,
  input  logic [31:0]       poll_data_p1,
  input  logic [31:0]       poll_data_p2,
  output logic              irq
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ1  = 3'd1,
    S_WAIT1 = 3'd2,
    S_NEXT  = 3'd3,
    S_REQ2  = 3'd4,
    S_WAIT2 = 3'd5
  } state_t;

  localparam logic [2:0]  A_CTRL   = 3'd0;
  localparam logic [2:0]  A_PERIOD = 3'd1;
  localparam logic [2:0]  A_STATUS = 3'd2;
  localparam logic [2:0]  A_DATA1  = 3'd3;
  localparam logic [2:0]  A_DATA2  = 3'd4;
  localparam logic [15:0] TO_LAST  = TIMEOUT_CYCLES - 16'd1;

  // Register state
  state_t      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        kick_q, kick_d;
  logic [31:0] period_q, period_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  status_q, status_d;
  logic [31:0] data_p1_q, data_p1_d;
  logic [31:0] data_p2_q, data_p2_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        irq_q, irq_d;

  // Decode / event strobes
  logic [2:0]  reg_idx;
  logic        wr_acc;
  logic        wr_ctrl, wr_period, wr_status;
  logic [31:0] period_wr;
  logic        any_en;
  logic        tick;
  logic        start;
  logic [1:0]  set_new;
  logic [1:0]  set_to;
  logic        set_ovr;
  logic        ld_p1, ld_p2;

  // Address bits outside the word-select field do not take part in decode.
  logic unused_addr;
  assign unused_addr = ^{PADDR[ADDR_W-1:5], PADDR[1:0]};

  assign PREADY   = 1'b1;
  assign PSLVERR  = 1'b0;
  assign irq      = irq_q;
  assign poll_req = {state_q == S_REQ2, state_q == S_REQ1};

  // APB write decode; a zero PERIOD is promoted to 1 so the counter never wraps.
  always_comb begin
    reg_idx   = PADDR[4:2];
    wr_acc    = PSEL & PENABLE & PWRITE;
    wr_ctrl   = wr_acc && (reg_idx == A_CTRL);
    wr_period = wr_acc && (reg_idx == A_PERIOD);
    wr_status = wr_acc && (reg_idx == A_STATUS);
    period_wr = (PWDATA == 32'd0) ? 32'd1 : PWDATA;
  end

  // Period counter: runs only while a port is enabled; a PERIOD write restarts it.
  always_comb begin
    any_en   = ctrl_q[0] | ctrl_q[1];
    tick     = any_en && (cnt_q == 32'd0);
    cnt_d    = cnt_q;
    period_d = period_q;
    if (wr_period) begin
      period_d = period_wr;
      cnt_d    = period_wr - 32'd1;
    end else if (any_en) begin
      cnt_d = (cnt_q == 32'd0) ? (period_q - 32'd1) : (cnt_q - 32'd1);
    end
  end

  // Round sequencer: P1 then P2, one outstanding poll at a time, with per-poll timeout.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    set_new  = 2'b00;
    set_to   = 2'b00;
    ld_p1    = 1'b0;
    ld_p2    = 1'b0;
    start    = tick | kick_q;
    // A start request is only honoured from IDLE; anything else is an overrun.
    set_ovr  = start && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ctrl_q[0])      state_d = S_REQ1;
          else if (ctrl_q[1]) state_d = S_REQ2;
        end
      end
      S_REQ1: begin
        to_cnt_d = 16'd0;
        state_d  = S_WAIT1;
      end
      S_WAIT1: begin
        // Completion takes priority over a timeout expiring in the same cycle.
        if (poll_done[0]) begin
          ld_p1      = 1'b1;
          set_new[0] = 1'b1;
          state_d    = S_NEXT;
        end else if (to_cnt_q == TO_LAST) begin
          set_to[0] = 1'b1;
          state_d   = S_NEXT;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      S_NEXT: begin
        // EN_P2 is sampled here, so clearing it mid-round skips only the P2 poll.
        state_d = ctrl_q[1] ? S_REQ2 : S_IDLE;
      end
      S_REQ2: begin
        to_cnt_d = 16'd0;
        state_d  = S_WAIT2;
      end
      S_WAIT2: begin
        if (poll_done[1]) begin
          ld_p2      = 1'b1;
          set_new[1] = 1'b1;
          state_d    = S_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          set_to[1] = 1'b1;
          state_d   = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control, status and data registers; hardware set beats a simultaneous W1C.
  always_comb begin
    ctrl_d    = wr_ctrl ? PWDATA[2:0] : ctrl_q;
    kick_d    = wr_ctrl & PWDATA[3];
    status_d  = status_q & ~(wr_status ? PWDATA[4:0] : 5'd0);
    status_d  = status_d | {set_ovr, set_to, set_new};
    data_p1_d = ld_p1 ? poll_data_p1 : data_p1_q;
    data_p2_d = ld_p2 ? poll_data_p2 : data_p2_q;
    irq_d     = ctrl_q[2] & (|status_q);
  end

  // Combinational read mux; unmapped word slots read as zero.
  always_comb begin
    PRDATA = 32'd0;
    case (reg_idx)
      A_CTRL:   PRDATA = {29'd0, ctrl_q};
      A_PERIOD: PRDATA = period_q;
      A_STATUS: PRDATA = {27'd0, status_q};
      A_DATA1:  PRDATA = data_p1_q;
      A_DATA2:  PRDATA = data_p2_q;
      default:  PRDATA = 32'd0;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      ctrl_q    <= 3'd0;
      kick_q    <= 1'b0;
      period_q  <= DEFAULT_PERIOD;
      cnt_q     <= DEFAULT_PERIOD - 32'd1;
      status_q  <= 5'd0;
      data_p1_q <= 32'd0;
      data_p2_q <= 32'd0;
      to_cnt_q  <= 16'd0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      kick_q    <= kick_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      data_p1_q <= data_p1_d;
      data_p2_q <= data_p2_d;
      to_cnt_q  <= to_cnt_d;
      irq_q     <= irq_d;
    end
  end

endmodule
